// File: rtl/counter_pkg.sv
// Shared FSM state encoding and mode constants for prog_counter.
package counter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    localparam logic [1:0] ModeFree    = 2'b00;
    localparam logic [1:0] ModeOneshot = 2'b01;
    localparam logic [1:0] ModeBounce  = 2'b10;

    // Mode 2'b11 is reserved and behaves as free-run.
    function automatic logic [1:0] eff_mode(logic [1:0] m);
        return (m == 2'b11) ? ModeFree : m;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler: emits a one-cycle tick every prescale+1 enabled cycles.
module counter_prescaler #(
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    // Tick and next prescaler value; clear wins over counting.
    always_comb begin
        tick  = enable && (cnt_q == prescale);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Prescaler register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down/bounce counter with prescaler and one-shot mode.
// Optional capture register enabled by defining PROG_COUNTER_CAPTURE_EN.
module prog_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            mode,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
`ifdef PROG_COUNTER_CAPTURE_EN
    input  logic                  capture,
    output logic [WIDTH-1:0]      cap_val,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  busy,
    output logic                  done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;   // bounce direction, 1 = up
    logic             tc_q, tc_d;
    logic             tick;
    logic             restart;
    logic             oneshot_term;
    logic [1:0]       mode_eff;

    assign mode_eff = eff_mode(mode);
    // DONE->RUN reloads the count and restarts the prescaler phase.
    assign restart  = !load && (state_q == StDone) && !stop && start;

    counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clock    (clock),
        .reset    (reset),
        .clear    (load || restart),
        .enable   (enable && (state_q == StRun) && !stop),
        .prescale (prescale),
        .tick     (tick)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop beats start, load freezes the state.
    always_comb begin
        state_d = state_q;
        if (!load) begin
            case (state_q)
                StIdle:  if (!stop && start) state_d = StRun;
                StRun: begin
                    if (stop) begin
                        state_d = StIdle;
                    end else if (oneshot_term) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (stop) begin
                        state_d = StIdle;
                    end else if (start) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
    end

    // Count datapath: load > restart > tick; counts above limit clamp to limit.
    always_comb begin
        count_d      = count_q;
        dir_d        = dir_q;
        tc_d         = 1'b0;
        oneshot_term = 1'b0;
        if (load) begin
            count_d = (load_val > limit) ? limit : load_val;
        end else if (restart) begin
            count_d = up_dn ? '0 : limit;
        end else if (tick) begin
            case (mode_eff)
                ModeOneshot: begin
                    if (up_dn) begin
                        count_d      = (count_q >= limit) ? limit : count_q + 1'b1;
                        oneshot_term = (count_d == limit);
                    end else begin
                        count_d      = (count_q > limit)  ? limit :
                                       (count_q == '0)    ? '0    : count_q - 1'b1;
                        oneshot_term = (count_d == '0);
                    end
                    tc_d = oneshot_term;
                end
                ModeBounce: begin
                    if (count_q > limit) begin
                        count_d = limit;
                        dir_d   = 1'b0;
                        tc_d    = dir_q || (limit == '0);
                    end else if (dir_q) begin
                        if (count_q == limit) begin
                            count_d = (limit == '0) ? '0 : count_q - 1'b1;
                            dir_d   = 1'b0;
                            tc_d    = (limit == '0);
                        end else begin
                            count_d = count_q + 1'b1;
                            if (count_d == limit) begin
                                dir_d = 1'b0;
                                tc_d  = 1'b1;
                            end
                        end
                    end else begin
                        if (count_q == '0) begin
                            count_d = (limit == '0) ? '0 : count_q + 1'b1;
                            dir_d   = 1'b1;
                            tc_d    = (limit == '0);
                        end else begin
                            count_d = count_q - 1'b1;
                            if (count_d == '0) begin
                                dir_d = 1'b1;
                                tc_d  = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    if (count_q > limit) begin
                        count_d = limit;
                    end else if (up_dn) begin
                        if (count_q == limit) begin
                            count_d = '0;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end else begin
                        if (count_q == '0) begin
                            count_d = limit;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = count_q - 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
            dir_q   <= 1'b1;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

`ifdef PROG_COUNTER_CAPTURE_EN
    logic [WIDTH-1:0] cap_q;

    // Snapshot of count taken when capture is high.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cap_q <= '0;
        end else if (capture) begin
            cap_q <= count_q;
        end
    end

    assign cap_val = cap_q;
`endif

endmodule

// File: tb/tb_prog_counter.sv
// Directed self-checking bench for prog_counter (WIDTH=8, PRESCALE_W=4).
module tb_prog_counter;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable, start, stop, up_dn, load;
    logic [1:0] mode;
    logic [7:0] load_val, limit, count;
    logic [3:0] prescale;
    logic       tc, busy, done;
`ifdef PROG_COUNTER_CAPTURE_EN
    logic       capture = 1'b0;
    logic [7:0] cap_val;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clock = ~clock;

    prog_counter #(
        .WIDTH      (8),
        .PRESCALE_W (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .prescale (prescale),
`ifdef PROG_COUNTER_CAPTURE_EN
        .capture  (capture),
        .cap_val  (cap_val),
`endif
        .count    (count),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge; inputs and outputs handled 1 time unit after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_ct(input string tag, input logic [7:0] c, input logic t);
        step();
        check_eq({tag, " count"}, 32'(count), 32'(c));
        check_eq({tag, " tc"}, 32'(tc), 32'(t));
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; start = 1'b0; stop = 1'b0; up_dn = 1'b1;
        load = 1'b0; mode = 2'b00; load_val = '0; limit = 8'd5; prescale = '0;

        // Reset state.
        step();
        check_eq("rst count", 32'(count), 0);
        check_eq("rst tc", 32'(tc), 0);
        check_eq("rst busy", 32'(busy), 0);
        check_eq("rst done", 32'(done), 0);
        reset = 1'b1;

        // Free-run up, limit 5.
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("fr busy", 32'(busy), 1);
        check_eq("fr count0", 32'(count), 0);
        expect_ct("fr1", 8'd1, 1'b0);
        expect_ct("fr2", 8'd2, 1'b0);
        expect_ct("fr3", 8'd3, 1'b0);
        expect_ct("fr4", 8'd4, 1'b0);
        expect_ct("fr5", 8'd5, 1'b0);
        expect_ct("fr_wrap", 8'd0, 1'b1);
        stop = 1'b1;
        expect_ct("fr_stop", 8'd0, 1'b0);
        stop = 1'b0;
        check_eq("fr stop busy", 32'(busy), 0);

        // One-shot down, limit 3.
        mode = 2'b01; up_dn = 1'b0; limit = 8'd3;
        load = 1'b1; load_val = 8'd3;
        expect_ct("os load", 8'd3, 1'b0);
        load = 1'b0;
        start = 1'b1;
        expect_ct("os start", 8'd3, 1'b0);
        start = 1'b0;
        expect_ct("os2", 8'd2, 1'b0);
        expect_ct("os1", 8'd1, 1'b0);
        expect_ct("os0", 8'd0, 1'b1);
        check_eq("os done", 32'(done), 1);
        check_eq("os busy", 32'(busy), 0);
        expect_ct("os hold", 8'd0, 1'b0);
        check_eq("os still done", 32'(done), 1);
        start = 1'b1;
        expect_ct("os restart", 8'd3, 1'b0);
        start = 1'b0;
        check_eq("os rerun busy", 32'(busy), 1);
        check_eq("os rerun done", 32'(done), 0);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // Bounce, limit 2.
        mode = 2'b10; limit = 8'd2;
        load = 1'b1; load_val = 8'd0;
        expect_ct("bn load", 8'd0, 1'b0);
        load = 1'b0;
        start = 1'b1;
        expect_ct("bn start", 8'd0, 1'b0);
        start = 1'b0;
        expect_ct("bn a", 8'd1, 1'b0);
        expect_ct("bn top", 8'd2, 1'b1);
        expect_ct("bn b", 8'd1, 1'b0);
        expect_ct("bn bottom", 8'd0, 1'b1);
        expect_ct("bn c", 8'd1, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // Prescale 2 with enable pattern 1,0,1,1.
        mode = 2'b00; up_dn = 1'b1; limit = 8'd10; prescale = 4'd2; enable = 1'b0;
        load = 1'b1; load_val = 8'd0;
        step();
        load = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        enable = 1'b1;
        expect_ct("ps e1", 8'd0, 1'b0);
        enable = 1'b0;
        expect_ct("ps e0", 8'd0, 1'b0);
        enable = 1'b1;
        expect_ct("ps e2", 8'd0, 1'b0);
        expect_ct("ps e3", 8'd1, 1'b0);

        // Load clamped to limit, overriding a same-cycle tick.
        prescale = 4'd0;
        load = 1'b1; load_val = 8'd200;
        expect_ct("ld clamp", 8'd10, 1'b0);
        load = 1'b0;
        check_eq("ld busy", 32'(busy), 1);
        expect_ct("ld wrap", 8'd0, 1'b1);
        stop = 1'b1;
        step();
        check_eq("stop idle", 32'(busy), 0);
        start = 1'b1;
        expect_ct("ss idle", 8'd0, 1'b0);
        check_eq("ss busy", 32'(busy), 0);
        check_eq("ss done", 32'(done), 0);
        start = 1'b0; stop = 1'b0;

        // Reset mid-run at count 7.
        load = 1'b1; load_val = 8'd6;
        step();
        load = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        expect_ct("pre rst", 8'd7, 1'b0);
        reset = 1'b0;
        expect_ct("mid rst", 8'd0, 1'b0);
        check_eq("mid rst busy", 32'(busy), 0);
        check_eq("mid rst done", 32'(done), 0);
        reset = 1'b1;

        // Limit lowered below count, then limit 0.
        load = 1'b1; load_val = 8'd7;
        step();
        load = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        limit = 8'd3;
        expect_ct("lim clamp", 8'd3, 1'b0);
        expect_ct("lim wrap", 8'd0, 1'b1);
        limit = 8'd0;
        expect_ct("lim0 a", 8'd0, 1'b1);
        expect_ct("lim0 b", 8'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning count/limit/load width in bits (legal 2..32).
REQ-002 SHALL have parameter PRESCALE_W, default 4, meaning prescaler register width in bits.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  advances the prescaler when high.
REQ-006 SHALL have port start, stop  input  1 each  run control.
REQ-007 SHALL have port mode  input  2  00 free-run, 01 one-shot, 10 bounce, 11 treated as 00.
REQ-008 SHALL have port up_dn  input  1  direction, 1 = up, for modes 00/01.
REQ-009 SHALL have port load, load_val  input  1 / WIDTH  synchronous preload.
REQ-010 SHALL have port limit  input  WIDTH  upper bound of count range 0..limit.
REQ-011 SHALL have port prescale  input  PRESCALE_W  tick every prescale+1 enabled cycles.
REQ-012 SHALL have port count  output  WIDTH  registered count value.
REQ-013 SHALL have ports tc, busy, done  output  1 each  terminal-count pulse, RUN state, DONE state.

Function
REQ-014 SHALL implement FSM IDLE, RUN, DONE: IDLE-start->RUN; RUN-stop->IDLE; RUN-one-shot terminal tick->DONE; DONE-start->RUN; DONE-stop->IDLE.
REQ-015 SHALL give stop priority over start in the same cycle.
REQ-016 SHALL count prescaler only in RUN with enable=1; tick when prescaler==prescale, then clear prescaler; prescale=0 gives a tick every enabled cycle.
REQ-017 SHALL, on tick counting up: count==limit -> 0, else count+1; counting down: count==0 -> limit, else count-1.
REQ-018 SHALL assert tc for exactly one cycle, registered, in the cycle where count shows the wrapped value (or the held terminal value in one-shot).
REQ-019 SHALL, in one-shot, hold count at the terminal value (limit up, 0 down) in DONE instead of wrapping.
REQ-020 SHALL, on DONE->RUN, reset count to 0 (up) or limit (down) and clear the prescaler.
REQ-021 SHALL, in bounce, ignore up_dn, count up to limit then down to 0 using an internal direction bit (reset = up), asserting tc at each reversal.
REQ-022 SHALL, on load in any state, set count to min(load_val, limit), clear the prescaler, suppress tc, and leave state unchanged; load overrides a same-cycle tick.
REQ-023 SHALL, with limit=0, hold count at 0 and assert tc on every tick.
REQ-024 SHALL clamp count to limit on the next tick if limit is lowered below the current count.
REQ-025 SHALL hold count in IDLE; stop preserves count and prescaler value.

Reset
REQ-026 SHALL, when reset=0 at a clock edge, set state IDLE, count 0, prescaler 0, direction up, tc 0, busy 0, done 0, regardless of other inputs including mid-run.

Configuration
REQ-027 SHALL, with PROG_COUNTER_CAPTURE_EN defined, add input capture (1) and output cap_val (WIDTH) holding count sampled the cycle capture=1 (reset 0).
REQ-028 SHALL, without PROG_COUNTER_CAPTURE_EN, omit capture and cap_val entirely; all other behaviour identical.

Structure
REQ-029 SHALL place state encoding (IDLE/RUN/DONE) and mode constants (FREE/ONESHOT/BOUNCE) in shared package counter_pkg.
REQ-030 SHALL implement the prescaler as sub-module counter_prescaler (inputs clock, reset, clear, enable, prescale; output tick).

Verification
REQ-031 SHALL cover: WIDTH=8, limit=5, prescale=0, mode=00, up -> count 0,1,2,3,4,5,0; tc high only with the 0 after 5.
REQ-032 SHALL cover: mode=01, down, limit=3, start -> 3,2,1,0 then DONE, count held 0, done=1, busy=0; start -> count 3, RUN.
REQ-033 SHALL cover: mode=10, limit=2 -> 0,1,2,1,0,1; tc on reaching 2 and on reaching 0.
REQ-034 SHALL cover: prescale=2, enable toggled 1,0,1,1 -> single count increment after third enabled cycle.
REQ-035 SHALL cover: load_val=200 with limit=10 and simultaneous tick -> count 10, tc 0; start+stop same cycle from IDLE -> stays IDLE.
REQ-036 SHALL cover: reset=0 mid-run at count 7 -> next edge count 0, IDLE, tc/busy/done 0.
